// File: rtl/uifdma_pkg.sv
// Shared types and constants for the fdma AXI write engine.
// Holds the FSM state encoding, AXI field encodings and a small min helper.
package uifdma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AW   = 2'd1,
        W    = 2'd2,
        B    = 2'd3
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam int         BOUNDARY_4K    = 4096;

    function automatic logic [16:0] min17(input logic [16:0] a, input logic [16:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/uifdma_burst_calc.sv
// Combinational burst sizing: the largest burst allowed by the remaining
// beat count, the maximum burst length and the distance to the next 4 KB page.
module uifdma_burst_calc
    import uifdma_pkg::*;
#(
    parameter int MAX_BURST_LEN = 64,
    parameter int BYTES_LOG2    = 4
) (
    input  logic [11:0] addr_lo,
    input  logic [15:0] remaining,
    output logic [8:0]  beats
);

    logic [12:0] to_4k;
    logic [16:0] lim;

    // 13 bits so an address at offset 0 yields a full 4096-byte page
    always_comb begin
        to_4k = (13'(BOUNDARY_4K) - {1'b0, addr_lo}) >> BYTES_LOG2;
        lim   = min17({1'b0, remaining}, 17'(MAX_BURST_LEN));
        lim   = min17(lim, {4'b0, to_4k});
        beats = 9'(lim);
    end

endmodule

// File: rtl/uifdma_axi_wr.sv
// FDMA write engine: splits one (address, size) request into AXI4 INCR bursts,
// one outstanding at a time, popping beats from a first-word-fall-through buffer.
module uifdma_axi_wr
    import uifdma_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int MAX_BURST_LEN  = 64
) (
    input  logic                        ui_clk,
    input  logic                        ui_rst,
    input  logic [AXI_ADDR_WIDTH-1:0]   fdma_waddr,
    input  logic                        fdma_wareq,
    input  logic [15:0]                 fdma_wsize,
    output logic                        fdma_wbusy,
    input  logic [AXI_DATA_WIDTH-1:0]   fdma_wdata,
    output logic                        fdma_wvalid,
    input  logic                        fdma_wready,
    output logic                        fdma_wdone,
    output logic                        fdma_werr,
    output logic [AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                  M_AXI_AWLEN,
    output logic [2:0]                  M_AXI_AWSIZE,
    output logic [1:0]                  M_AXI_AWBURST,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                        M_AXI_WLAST,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY
);

    localparam int BYTES_LOG2 = $clog2(AXI_DATA_WIDTH / 8);

    state_t                      state;
    logic [15:0]                 remaining;
    logic [7:0]                  beat_cnt;
    logic [8:0]                  cur_beats;
    logic [AXI_ADDR_WIDTH-1:0]   next_addr;
    logic [15:0]                 next_remaining;
    logic [11:0]                 calc_addr;
    logic [15:0]                 calc_rem;
    logic [8:0]                  calc_beats;
    logic                        w_xfer;
    logic                        resp_err;
    logic                        unused_bresp;

    assign cur_beats      = {1'b0, M_AXI_AWLEN} + 9'd1;
    assign next_addr      = M_AXI_AWADDR + (AXI_ADDR_WIDTH'(cur_beats) << BYTES_LOG2);
    assign next_remaining = remaining - 16'(cur_beats);

    // The first burst is sized from the request itself, later ones from the advanced position
    assign calc_addr = (state == IDLE) ? fdma_waddr[11:0] : next_addr[11:0];
    assign calc_rem  = (state == IDLE) ? fdma_wsize       : next_remaining;

    uifdma_burst_calc #(
        .MAX_BURST_LEN (MAX_BURST_LEN),
        .BYTES_LOG2    (BYTES_LOG2)
    ) u_burst_calc (
        .addr_lo   (calc_addr),
        .remaining (calc_rem),
        .beats     (calc_beats)
    );

    assign M_AXI_AWSIZE  = 3'(BYTES_LOG2);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_WDATA   = fdma_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = (state == W) && fdma_wready;
    assign M_AXI_WLAST   = (state == W) && (beat_cnt == M_AXI_AWLEN);
    assign w_xfer        = M_AXI_WVALID && M_AXI_WREADY;
    assign fdma_wvalid   = w_xfer;

    // SLVERR and DECERR both carry bit 1; EXOKAY is treated as success
    assign resp_err      = M_AXI_BRESP[1] != AXI_RESP_OKAY[1];
    assign unused_bresp  = M_AXI_BRESP[0];

    always_ff @(posedge ui_clk) begin
        if (ui_rst) begin
            state         <= IDLE;
            remaining     <= '0;
            beat_cnt      <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWLEN   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            fdma_wbusy    <= 1'b0;
            fdma_wdone    <= 1'b0;
            fdma_werr     <= 1'b0;
        end else begin
            fdma_wdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (fdma_wareq) begin
                        fdma_werr <= 1'b0;
                        if (fdma_wsize == 16'd0) begin
                            fdma_wdone <= 1'b1;
                        end else begin
                            M_AXI_AWADDR  <= fdma_waddr;
                            M_AXI_AWLEN   <= 8'(calc_beats - 9'd1);
                            M_AXI_AWVALID <= 1'b1;
                            remaining     <= fdma_wsize;
                            fdma_wbusy    <= 1'b1;
                            state         <= AW;
                        end
                    end
                end
                AW: begin
                    if (M_AXI_AWREADY) begin
                        M_AXI_AWVALID <= 1'b0;
                        beat_cnt      <= '0;
                        state         <= W;
                    end
                end
                W: begin
                    if (w_xfer) begin
                        beat_cnt <= 8'(beat_cnt + 8'd1);
                        if (M_AXI_WLAST) begin
                            M_AXI_BREADY <= 1'b1;
                            state        <= B;
                        end
                    end
                end
                B: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        remaining    <= next_remaining;
                        if (resp_err) begin
                            fdma_werr <= 1'b1;
                        end
                        if (next_remaining != 16'd0) begin
                            M_AXI_AWADDR  <= next_addr;
                            M_AXI_AWLEN   <= 8'(calc_beats - 9'd1);
                            M_AXI_AWVALID <= 1'b1;
                            state         <= AW;
                        end else begin
                            fdma_wbusy <= 1'b0;
                            fdma_wdone <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uifdma_axi_wr.sv
// Bench for uifdma_axi_wr: AXI slave and FWFT source models with random
// backpressure, checked against a burst-splitting reference computed per request.
module tb_uifdma_axi_wr;

    localparam int DW  = 128;
    localparam int AWD = 32;
    localparam int MBL = 64;
    localparam int BPB = DW / 8;

    logic            ui_clk = 1'b0;
    logic            ui_rst;
    logic [AWD-1:0]  fdma_waddr;
    logic            fdma_wareq;
    logic [15:0]     fdma_wsize;
    logic            fdma_wbusy;
    logic [DW-1:0]   fdma_wdata;
    logic            fdma_wvalid;
    logic            fdma_wready;
    logic            fdma_wdone;
    logic            fdma_werr;
    logic [AWD-1:0]  M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;

    always #5 ui_clk = ~ui_clk;

    uifdma_axi_wr #(
        .AXI_DATA_WIDTH (DW),
        .AXI_ADDR_WIDTH (AWD),
        .MAX_BURST_LEN  (MBL)
    ) dut (
        .ui_clk        (ui_clk),
        .ui_rst        (ui_rst),
        .fdma_waddr    (fdma_waddr),
        .fdma_wareq    (fdma_wareq),
        .fdma_wsize    (fdma_wsize),
        .fdma_wbusy    (fdma_wbusy),
        .fdma_wdata    (fdma_wdata),
        .fdma_wvalid   (fdma_wvalid),
        .fdma_wready   (fdma_wready),
        .fdma_wdone    (fdma_wdone),
        .fdma_werr     (fdma_werr),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWLEN   (M_AXI_AWLEN),
        .M_AXI_AWSIZE  (M_AXI_AWSIZE),
        .M_AXI_AWBURST (M_AXI_AWBURST),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WLAST   (M_AXI_WLAST),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY)
    );

    int errors = 0;
    int checks = 0;

    logic [DW-1:0]  src_q[$];
    logic [DW-1:0]  exp_data[$];
    logic [AWD-1:0] exp_addr[$];
    int             exp_len[$];
    logic [AWD-1:0] aw_addr_log[$];
    logic [7:0]     aw_len_log[$];
    logic [DW-1:0]  w_log[$];
    bit             wl_log[$];

    int   wlast_cnt, b_done, pop_cnt, done_cnt, busy_cnt, viol;
    int   cyc = 0, req_cyc, last_b_cyc, done_cyc;
    logic werr_at_done;
    int   aw_delay = 0, aw_wait = 0, err_burst = -1;
    bit   w_rand = 0, s_rand = 0;
    logic prev_aw_pend = 1'b0;
    logic [AWD-1:0] prev_awaddr;
    logic [7:0]     prev_awlen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        src_q.delete(); aw_addr_log.delete(); aw_len_log.delete();
        w_log.delete(); wl_log.delete();
        wlast_cnt = 0; b_done = 0; pop_cnt = 0; done_cnt = 0; busy_cnt = 0; viol = 0;
        req_cyc = 0; last_b_cyc = 0; done_cyc = 0; werr_at_done = 1'bx;
    endtask

    // Bus observer: logs handshakes and counts protocol violations
    always @(posedge ui_clk) begin
        if (!ui_rst) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_addr_log.push_back(M_AXI_AWADDR);
                aw_len_log.push_back(M_AXI_AWLEN);
            end
            if (M_AXI_WVALID && (aw_addr_log.size() == wlast_cnt)) viol++;
            if (fdma_wvalid !== (M_AXI_WVALID && M_AXI_WREADY)) viol++;
            if (prev_aw_pend && (M_AXI_AWVALID !== 1'b1 || M_AXI_AWADDR !== prev_awaddr ||
                                 M_AXI_AWLEN !== prev_awlen)) viol++;
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_log.push_back(M_AXI_WDATA);
                wl_log.push_back(M_AXI_WLAST);
                if (M_AXI_WLAST) wlast_cnt++;
            end
            if (fdma_wvalid) begin
                pop_cnt++;
                if (src_q.size() > 0) void'(src_q.pop_front());
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                b_done++;
                last_b_cyc = cyc;
            end
            if (fdma_wdone) begin
                done_cnt++;
                done_cyc = cyc;
                werr_at_done = fdma_werr;
            end
            if (fdma_wbusy) busy_cnt++;
            if (fdma_wareq && !fdma_wbusy) req_cyc = cyc;
        end
        prev_aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY && !ui_rst;
        prev_awaddr  = M_AXI_AWADDR;
        prev_awlen   = M_AXI_AWLEN;
        cyc++;
    end

    // AW slave with configurable acceptance delay
    initial begin
        M_AXI_AWREADY = 1'b0;
        forever begin
            @(negedge ui_clk);
            if (M_AXI_AWVALID && !M_AXI_AWREADY && !ui_rst) begin
                if (aw_wait >= aw_delay) M_AXI_AWREADY = 1'b1;
                else aw_wait++;
            end else begin
                M_AXI_AWREADY = 1'b0;
                aw_wait = 0;
            end
        end
    end

    // B slave: one response per completed burst, error injected on burst err_burst
    initial begin
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
        forever begin
            @(negedge ui_clk);
            if (!ui_rst && (b_done < wlast_cnt)) begin
                M_AXI_BVALID = 1'b1;
                M_AXI_BRESP  = (b_done == err_burst) ? 2'b10 : 2'b00;
            end else begin
                M_AXI_BVALID = 1'b0;
                M_AXI_BRESP  = 2'b00;
            end
        end
    end

    // FWFT source and W-channel ready, optionally randomized
    initial begin
        fdma_wready  = 1'b0;
        fdma_wdata   = '0;
        M_AXI_WREADY = 1'b0;
        forever begin
            @(negedge ui_clk);
            #1;
            M_AXI_WREADY = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            fdma_wready  = (s_rand ? 1'($urandom_range(0, 1)) : 1'b1) && (src_q.size() > 0);
            fdma_wdata   = (src_q.size() > 0) ? src_q[0] : '0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wbusy"},   fdma_wbusy,    1'b0);
        chk({tag, "_wvalid"},  fdma_wvalid,   1'b0);
        chk({tag, "_wdone"},   fdma_wdone,    1'b0);
        chk({tag, "_werr"},    fdma_werr,     1'b0);
        chk({tag, "_awvalid"}, M_AXI_AWVALID, 1'b0);
        chk({tag, "_axi_wvalid"}, M_AXI_WVALID, 1'b0);
        chk({tag, "_wlast"},   M_AXI_WLAST,   1'b0);
        chk({tag, "_bready"},  M_AXI_BREADY,  1'b0);
        chk({tag, "_awaddr"},  M_AXI_AWADDR,  32'h0);
        chk({tag, "_awlen"},   M_AXI_AWLEN,   8'h0);
    endtask

    // Issue one request, wait for completion and compare against the splitting model
    task automatic run_req(input logic [AWD-1:0] a, input int s, input int err_idx,
                           input logic exp_err, input string tag);
        int             rem, len, to4k, first_bad, wl_bad, cum, n;
        logic [AWD-1:0] ad;
        logic [DW-1:0]  d;
        bit             exp_last[$];

        exp_addr.delete(); exp_len.delete(); exp_data.delete();
        rem = s;
        ad  = a;
        while (rem > 0) begin
            to4k = (4096 - int'(ad % 4096)) / BPB;
            len  = rem;
            if (len > MBL)  len = MBL;
            if (len > to4k) len = to4k;
            exp_addr.push_back(ad);
            exp_len.push_back(len);
            for (int k = 0; k < len; k++) exp_last.push_back(k == len - 1);
            ad  = ad + AWD'(len * BPB);
            rem = rem - len;
        end

        clear_logs();
        err_burst = err_idx;
        for (int i = 0; i < s; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            src_q.push_back(d);
            exp_data.push_back(d);
        end

        @(negedge ui_clk);
        fdma_waddr = a;
        fdma_wsize = 16'(s);
        fdma_wareq = 1'b1;
        @(negedge ui_clk);
        fdma_wareq = 1'b0;
        chk({tag, "_busy_after_req"},    fdma_wbusy,    1'b1);
        chk({tag, "_awvalid_after_req"}, M_AXI_AWVALID, 1'b1);
        chk({tag, "_werr_cleared"},      fdma_werr,     1'b0);

        for (int t = 0; t < 20000 && done_cnt == 0; t++) @(negedge ui_clk);
        chk({tag, "_done_within_budget"}, done_cnt > 0, 1'b1);
        repeat (3) @(negedge ui_clk);
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_idle"},   fdma_wbusy, 1'b0);

        chk({tag, "_aw_count"}, aw_addr_log.size(), exp_addr.size());
        n = (aw_addr_log.size() < exp_addr.size()) ? aw_addr_log.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_awaddr%0d", tag, i), aw_addr_log[i], exp_addr[i]);
            chk($sformatf("%s_awlen%0d", tag, i),  aw_len_log[i],  exp_len[i] - 1);
        end

        chk({tag, "_w_beats"}, w_log.size(), s);
        first_bad = s;
        wl_bad    = 0;
        cum       = (w_log.size() < s) ? w_log.size() : s;
        for (int i = cum - 1; i >= 0; i--) begin
            if (w_log[i] !== exp_data[i]) first_bad = i;
            if (wl_log[i] != exp_last[i]) wl_bad++;
        end
        chk({tag, "_wdata_first_bad_beat"}, first_bad, s);
        chk({tag, "_wlast_misplaced"},      wl_bad, 0);
        chk({tag, "_pops"},                 pop_cnt, s);
        chk({tag, "_b_to_done"},            done_cyc - last_b_cyc, 1);
        chk({tag, "_busy_span"},            busy_cnt, last_b_cyc - req_cyc);
        chk({tag, "_werr_at_done"},         werr_at_done, exp_err);
        chk({tag, "_werr_after"},           fdma_werr, exp_err);
        chk({tag, "_protocol_viol"},        viol, 0);
    endtask

    initial begin
        ui_rst     = 1'b1;
        fdma_waddr = '0;
        fdma_wareq = 1'b0;
        fdma_wsize = '0;
        clear_logs();
        repeat (3) @(negedge ui_clk);
        chk_reset_outputs("reset");
        chk("awsize",  M_AXI_AWSIZE,  3'd4);
        chk("awburst", M_AXI_AWBURST, 2'b01);
        chk("wstrb",   M_AXI_WSTRB,   {16{1'b1}});
        ui_rst = 1'b0;
        repeat (2) @(negedge ui_clk);

        run_req(32'h1000, 16, -1, 1'b0, "single16");
        run_req(32'h0000, 200, -1, 1'b0, "split200");
        run_req(32'h0000, 150, 1, 1'b1, "bresp_err");
        run_req(32'h0FC0, 8, -1, 1'b0, "cross4k");

        aw_delay = 5; w_rand = 1; s_rand = 1;
        run_req({20'h0, 8'($urandom_range(0, 255)), 4'h0}, 64, -1, 1'b0, "rand64");
        for (int r = 0; r < 3; r++) begin
            run_req({12'h0, 16'($urandom_range(0, 65535)), 4'h0}, $urandom_range(1, 300),
                    -1, 1'b0, $sformatf("rand_mix%0d", r));
        end
        aw_delay = 0; w_rand = 0; s_rand = 0;

        // Reset while beat 10 of a 32-beat burst is on the bus
        clear_logs();
        for (int i = 0; i < 32; i++) src_q.push_back({$urandom, $urandom, $urandom, $urandom});
        @(negedge ui_clk);
        fdma_waddr = 32'h2000;
        fdma_wsize = 16'd32;
        fdma_wareq = 1'b1;
        @(negedge ui_clk);
        fdma_wareq = 1'b0;
        for (int t = 0; t < 2000 && pop_cnt < 9; t++) @(negedge ui_clk);
        chk("rst_reached_beat10", pop_cnt, 9);
        ui_rst = 1'b1;
        @(negedge ui_clk);
        chk_reset_outputs("midburst_rst");
        ui_rst = 1'b0;
        repeat (2) @(negedge ui_clk);
        run_req(32'h3000, 4, -1, 1'b0, "post_rst");

        // Zero-length request completes immediately with no AXI traffic
        clear_logs();
        @(negedge ui_clk);
        fdma_waddr = 32'h5000;
        fdma_wsize = 16'd0;
        fdma_wareq = 1'b1;
        @(negedge ui_clk);
        fdma_wareq = 1'b0;
        chk("zero_done_pulse", fdma_wdone,    1'b1);
        chk("zero_busy",       fdma_wbusy,    1'b0);
        chk("zero_awvalid",    M_AXI_AWVALID, 1'b0);
        @(negedge ui_clk);
        chk("zero_done_single", fdma_wdone, 1'b0);
        repeat (3) @(negedge ui_clk);
        chk("zero_no_aw", aw_addr_log.size(), 0);
        chk("zero_no_pop", pop_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
